// File: rtl/surfboard_operand_loader.sv
// Serial-to-matrix operand loader for the 2x2 surfboard multiplier.
// Assembles 8-beat frames into A/B operands behind a double-buffered valid/ready output.
module surfboard_operand_loader #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [0:3][W-1:0]     out_A,
    output logic [0:3][W-1:0]     out_B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [7:0]            err_cnt
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state, state_next;

    logic           started;
    logic [2:0]     cnt, cnt_next;
    logic [0:3][W-1:0] asm_A, asm_B;

    logic accept, drain;
    logic wr_asm, load_beat, load_asm, err_set;

    // started keeps in_ready low until the first edge after reset releases
    assign in_ready = started && (state != HOLD);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            cnt     <= 3'd0;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            started <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_asm     = 1'b0;
        load_beat  = 1'b0;
        load_asm   = 1'b0;
        err_set    = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    if (cnt == 3'd7) begin
                        cnt_next = 3'd0;
                        if (!in_last) begin
                            err_set    = 1'b1;
                            state_next = DROP;
                        end else if (!out_valid || drain) begin
                            load_beat = 1'b1;
                        end else begin
                            wr_asm     = 1'b1;
                            state_next = HOLD;
                        end
                    end else if (in_last) begin
                        err_set  = 1'b1;
                        cnt_next = 3'd0;
                    end else begin
                        wr_asm   = 1'b1;
                        cnt_next = cnt + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (drain) begin
                    load_asm   = 1'b1;
                    state_next = FILL;
                end
            end
            DROP: begin
                if (accept && in_last) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // The 8th beat bypasses assembly so a free holding register fills in the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_A     <= '0;
            asm_B     <= '0;
            out_A     <= '0;
            out_B     <= '0;
            out_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (wr_asm) begin
                if (!cnt[2]) begin
                    asm_A[cnt[1:0]] <= in_data;
                end else begin
                    asm_B[cnt[1:0]] <= in_data;
                end
            end
            if (load_beat) begin
                out_A     <= asm_A;
                out_B     <= {asm_B[0], asm_B[1], asm_B[2], in_data};
                out_valid <= 1'b1;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end else if (load_asm) begin
                out_A     <= asm_A;
                out_B     <= asm_B;
                out_valid <= 1'b1;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            err <= err_set;
            if (err_set && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_surfboard_operand_loader.sv
// Scoreboard bench for surfboard_operand_loader: directed frames, framing errors,
// mid-frame reset, counter wrap (via a CNT_W=3 twin) and err_cnt saturation.
module tb_surfboard_operand_loader;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [0:3][7:0]   out_A, out_B;
    logic              out_valid;
    logic              out_ready;
    logic              err;
    logic [15:0]       frame_cnt;
    logic [7:0]        err_cnt;

    logic              s_in_ready, s_out_valid, s_err;
    logic [0:3][7:0]   s_out_A, s_out_B;
    logic [2:0]        s_frame_cnt;
    logic [7:0]        s_err_cnt;

    typedef struct {
        logic [0:3][7:0] a;
        logic [0:3][7:0] b;
        logic [15:0]     cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_frames = 0;
    int   err_seen = 0;
    logic prev_hold = 1'b0;
    logic [0:3][7:0] prev_A, prev_B;

    surfboard_operand_loader #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_A(out_A), .out_B(out_B), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    surfboard_operand_loader #(.W(8), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(s_in_ready), .out_A(s_out_A), .out_B(s_out_B), .out_valid(s_out_valid),
        .out_ready(out_ready), .err(s_err), .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every drain and checks hold stability
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (err) err_seen++;
            if (prev_hold) begin
                check("hold_stable_A", out_A, prev_A);
                check("hold_stable_B", out_B, prev_B);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_frame: got A=%h with no frame expected", out_A);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame_A", out_A, e.a);
                    check("frame_B", out_B, e.b);
                    check("frame_cnt_at_drain", frame_cnt, e.cnt);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_A    = out_A;
            prev_B    = out_B;
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout: in_ready stuck at 0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            send_beat(base + 8'(i), i == 7);
        end
        exp_frames++;
        e.a   = {base, base + 8'd1, base + 8'd2, base + 8'd3};
        e.b   = {base + 8'd4, base + 8'd5, base + 8'd6, base + 8'd7};
        e.cnt = 16'(exp_frames);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        err_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_A", out_A, 0);
        check("rst_out_B", out_B, 0);
        check("rst_err", err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        check("post_rst_in_ready_high", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        do_reset();

        // Single frame, 1-cycle latency
        send_frame(8'd1);
        check("latency_out_valid", out_valid, 1);
        check("latency_frame_cnt", frame_cnt, 1);
        @(posedge clk);
        #1;
        check("drained_out_valid", out_valid, 0);

        // Back-to-back frames with downstream stalled
        out_ready = 1'b0;
        send_frame(8'd11);
        send_frame(8'd21);
        check("hold_in_ready", in_ready, 0);
        repeat (6) @(posedge clk);
        #1;
        check("hold_out_A_first", out_A, {8'd11, 8'd12, 8'd13, 8'd14});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_exit_out_valid", out_valid, 1);
        check("hold_exit_in_ready", in_ready, 1);
        check("hold_exit_out_A", out_A, {8'd21, 8'd22, 8'd23, 8'd24});
        check("hold_exit_frame_cnt", frame_cnt, 3);
        @(posedge clk);
        #1;

        // Early last on the 5th beat, then a clean frame
        for (int i = 0; i < 5; i++) send_beat(8'(100 + i), i == 4);
        @(posedge clk);
        #1;
        check("early_err_cnt", err_cnt, 1);
        check("early_err_seen", err_seen, 1);
        send_frame(8'd9);

        // Ten beats, last only on the 10th
        for (int i = 0; i < 10; i++) send_beat(8'(200 + i), i == 9);
        repeat (2) @(posedge clk);
        #1;
        check("miss_err_cnt", err_cnt, 2);
        check("miss_err_seen", err_seen, 2);
        send_frame(8'd40);
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_frame_cnt", frame_cnt, 5);

        // Reset mid-frame, then a full frame
        for (int i = 0; i < 3; i++) send_beat(8'(60 + i), 1'b0);
        do_reset();
        send_frame(8'd70);
        check("after_reset_frame_cnt", frame_cnt, 1);

        // Seven more frames: 8 total wraps the CNT_W=3 twin to 0
        for (int f = 0; f < 7; f++) send_frame(8'(80 + 8 * f));
        check("wrap_main_frame_cnt", frame_cnt, 8);
        check("wrap_small_frame_cnt", s_frame_cnt, 0);

        // 260 single-beat early-last errors saturate err_cnt
        for (int i = 0; i < 260; i++) send_beat(8'(i), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("sat_err_cnt", err_cnt, 255);
        check("sat_err_seen", err_seen, 260);
        check("sat_out_valid", out_valid, 0);

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
